stack_sequencer: RTL
====================

# stack_sequencer

Executes the stack work of one decoded instruction: the `push` and `pop` 16-bit masks from the decode record. It walks each mask one word at a time, issues stack-segment bus cycles, and returns popped words to the register file. It sits downstream of instruction decode, beside the execute stage, which starts it and stalls on `busy`.

## Interface

Parameters:
- none

Ports:
- `clk`  in  1  core clock
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle strobe; accepted only while `busy`=0
- `push_mask`  in  16  decode `push` field; bit order AW(0) … PC(14), OPERAND(15)
- `pop_mask`  in  16  decode `pop` field, same bit order
- `sp_in`  in  16  SP value at `start`
- `reg_sel`  out  4  register index (mask bit number) being pushed
- `reg_rdata`  in  16  combinational register-file read of `reg_sel`; OPERAND(15) supplies the execute operand
- `reg_we`  out  1  one-cycle write strobe for a popped word
- `reg_wsel`  out  4  popped word's mask bit number
- `reg_wdata`  out  16  popped word
- `mem_req`  out  1  bus request, held until `mem_ack`
- `mem_wr`  out  1  1=write (push), 0=read (pop)
- `mem_addr`  out  16  SS-relative offset
- `mem_wdata`  out  16  push data
- `mem_ack`  in  1  bus cycle complete; `mem_rdata` valid this cycle for reads
- `mem_rdata`  in  16  read data
- `mem_lock`  out  1  bus lock (see Configuration)
- `sp_out`  out  16  final SP
- `sp_we`  out  1  one-cycle strobe with `done`
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle completion pulse

## Operation

- States: IDLE, POP, PUSH, FINISH.
- IDLE + `start`:
  - latch masks and `sp_in` into internal `sp` and `sp_orig`.
  - Go to POP if `pop_mask`≠0, else PUSH if `push_mask`≠0, else FINISH.
- Pops are executed before pushes.
- POP: services remaining pop bits, highest set bit first.
  - Read at `sp`.
  - On `mem_ack`: `sp`←`sp`+2, clear the bit, and pulse `reg_we` with `reg_wsel`=bit and `reg_wdata`=`mem_rdata`.
  - Bit 5 (BP_SKIP_SP): the read is still performed, but the data is discarded and `reg_we` stays 0.
  - Bit 4 (SP): the popped value replaces `sp`; the +2 is not applied.
  - When the mask is empty, go to PUSH or FINISH.
- PUSH: services remaining push bits, lowest set bit first.
  - Address is `sp`−2.
  - `mem_wdata`=`reg_rdata` with `reg_sel`=bit. Bit 4 (SP) instead pushes `sp_orig`.
  - On `mem_ack`: `sp`←`sp`−2 and clear the bit.
  - Bit 5 is ignored in `push_mask`.
  - When the mask is empty, go to FINISH.
- FINISH: pulse `done` and `sp_we` with `sp_out`=`sp`, then go to IDLE.
- Arithmetic is 16-bit modulo: SP 0x0000 push → address 0xFFFE; pop at 0xFFFE → `sp`=0x0000.
- `start` while `busy` is ignored.
- Reset (any time, including mid-bus-cycle): return to IDLE and drive every output 0. A pending bus cycle is abandoned; the bus must tolerate a dropped `mem_req`.

## Timing

- Reset values: all outputs 0.
- `busy`:
  - rises the cycle after the accepted `start`.
  - stays high through FINISH.
  - falls in the cycle after `done`.
- `mem_req`:
  - rises the cycle after `start`.
  - `mem_addr`, `mem_wr` and `mem_wdata` are stable while `mem_req`=1 and `mem_ack`=0.
- `mem_ack` in cycle N: the next element's request is presented in cycle N+1. `mem_req` stays high with no gap.
- `reg_we`: registered, in the cycle after the corresponding `mem_ack`.
- `done`: the cycle after the final `mem_ack`.
- Empty masks: `done` 2 cycles after `start`, with no bus activity.
- Minimum latency for n words with zero-wait ack: n+2 cycles from `start` to `done`.
- `mem_ack` while `mem_req`=0 is ignored.

## Configuration

- `STACK_SEQ_BUSLOCK_EN` defined:
  - `mem_lock`=1 from the first `mem_req` rise until the cycle `done` pulses.
  - Keeps multi-word frames atomic.
- `STACK_SEQ_BUSLOCK_EN` undefined: `mem_lock` tied 0, and its logic is removed.

## Test plan

- PUSH AW: `push_mask`=0x0001, `sp_in`=0x0100, AW=0x1234, zero-wait ack.
  - Expect one write of 0x1234 at 0x00FE.
  - Expect `done`+`sp_we` with `sp_out`=0x00FE at cycle 3.
- Interrupt frame: `push_mask`=0x4C00 (PSW, PS, PC), `sp_in`=0x0000.
  - Expect writes in order PSW@0xFFFE, PS@0xFFFC, PC@0xFFFA.
  - Expect `sp_out`=0xFFFA.
- RETI: `pop_mask`=0x4C00, `sp_in`=0x0200, memory 0x0200=0xAAAA, 0x0202=0xBBBB, 0x0204=0xCCCC.
  - Expect `reg_we` in order PC(14)=0xAAAA, PS(11)=0xBBBB, PSW(10)=0xCCCC.
  - Expect `sp_out`=0x0206.
- POP-all: `pop_mask`=0x01EF (no bit 4, with bit 5).
  - Expect 8 reads and 7 `reg_we` pulses; bit 5 gives no `reg_we`.
  - Expect `sp_out`=`sp_in`+16.
- Wait states and reset:
  - Push with ack delayed 3 cycles: `mem_req` and `mem_addr` are stable throughout, and `done` comes 1 cycle after ack.
  - Repeat with `reset_n` low during the wait: all outputs 0 next edge, and a new `start` behaves normally.
- `STACK_SEQ_BUSLOCK_EN`:
  - with the macro, a 3-word push holds `mem_lock`=1 continuously through `done`.
  - without it, `mem_lock` stays 0.

Source files
------------

// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: stack-segment bus between the stack sequencer (master) and memory (slave)
//   mem_req   master->slave  request, held until mem_ack
//   mem_wr    master->slave  1 = write (push), 0 = read (pop)
//   mem_addr  master->slave  SS-relative offset
//   mem_wdata master->slave  push data
//   mem_lock  master->slave  bus lock for the whole frame
//   mem_ack   slave->master  cycle complete; mem_rdata valid for reads
//   mem_rdata slave->master  read data
interface stack_sequencer_if;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_lock;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  modport master (output mem_req, mem_wr, mem_addr, mem_wdata, mem_lock, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_wr, mem_addr, mem_wdata, mem_lock, output mem_ack, mem_rdata);
endinterface

// File: rtl/stack_sequencer.sv
// stack_sequencer: walks the pop then push masks of one instruction, one stack word per bus cycle
//   clk, reset_n        core clock, asynchronous active-low reset
//   start               strobe, accepted only while busy = 0
//   push_mask/pop_mask  word masks, bit order AW(0) .. PC(14), OPERAND(15)
//   sp_in               SP at start
//   reg_sel/reg_rdata   register-file read port for pushes
//   reg_we/wsel/wdata   register-file write strobe for popped words
//   bus                 stack-segment bus (stack_sequencer_if.master)
//   sp_out/sp_we        final SP with its one-cycle write strobe
//   busy/done           sequence in progress / one-cycle completion pulse
// Optional: define STACK_SEQ_BUSLOCK_EN to hold mem_lock across the whole frame.
module stack_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] push_mask,
  input  logic [15:0] pop_mask,
  input  logic [15:0] sp_in,
  output logic [3:0]  reg_sel,
  input  logic [15:0] reg_rdata,
  output logic        reg_we,
  output logic [3:0]  reg_wsel,
  output logic [15:0] reg_wdata,
  stack_sequencer_if.master bus,
  output logic [15:0] sp_out,
  output logic        sp_we,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, POP, PUSH, FINISH} state_t;
  state_t      r_state;
  logic [15:0] r_pop, r_push, r_sp, r_sp_orig, r_addr, r_reg_wdata, r_sp_out;
  logic [3:0]  r_reg_sel, r_reg_wsel;
  logic        r_req, r_wr, r_reg_we, r_sp_we, r_busy, r_done;
  function automatic logic [3:0] f_msb(input logic [15:0] m);
    f_msb = 4'd0;
    for (int i = 0; i < 16; i++) if (m[i]) f_msb = 4'(i);
  endfunction
  function automatic logic [3:0] f_lsb(input logic [15:0] m);
    f_lsb = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) f_lsb = 4'(i);
  endfunction
  // bit 5 has no meaning in a push mask, so it never enters the push walk
  logic [15:0] w_in_push, w_pop_left, w_push_left, w_pop_sp, w_push_sp;
  logic [3:0]  w_pop_bit, w_push_bit, w_next_push_bit;
  logic        w_ack;
  assign w_in_push       = push_mask & 16'hFFDF;
  assign w_ack           = bus.mem_ack & r_req;
  assign w_pop_bit       = f_msb(r_pop);
  assign w_push_bit      = f_lsb(r_push);
  assign w_pop_left      = r_pop & ~(16'd1 << w_pop_bit);
  assign w_push_left     = r_push & ~(16'd1 << w_push_bit);
  assign w_next_push_bit = f_lsb(w_push_left);
  // popping SP loads the popped value instead of stepping past it
  assign w_pop_sp        = (w_pop_bit == 4'd4) ? bus.mem_rdata : r_sp + 16'd2;
  assign w_push_sp       = r_sp - 16'd2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pop       <= 16'd0;
      r_push      <= 16'd0;
      r_sp        <= 16'd0;
      r_sp_orig   <= 16'd0;
      r_addr      <= 16'd0;
      r_reg_sel   <= 4'd0;
      r_reg_we    <= 1'b0;
      r_reg_wsel  <= 4'd0;
      r_reg_wdata <= 16'd0;
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_sp_out    <= 16'd0;
      r_sp_we     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_reg_we <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_pop     <= pop_mask;
          r_push    <= w_in_push;
          r_sp      <= sp_in;
          r_sp_orig <= sp_in;
          r_busy    <= 1'b1;
          r_state   <= (|pop_mask) ? POP : (|w_in_push) ? PUSH : FINISH;
          r_req     <= |{pop_mask, w_in_push};
          r_wr      <= ~|pop_mask & |w_in_push;
          r_addr    <= (|pop_mask) ? sp_in : sp_in - 16'd2;
          r_reg_sel <= f_lsb(w_in_push);
        end
        POP: if (w_ack) begin
          r_pop       <= w_pop_left;
          r_sp        <= w_pop_sp;
          r_reg_we    <= (w_pop_bit != 4'd5);
          r_reg_wsel  <= w_pop_bit;
          r_reg_wdata <= bus.mem_rdata;
          if (|w_pop_left)
            r_addr <= w_pop_sp;
          else if (|r_push) begin
            r_state   <= PUSH;
            r_wr      <= 1'b1;
            r_addr    <= w_pop_sp - 16'd2;
            r_reg_sel <= w_push_bit;
          end else begin
            r_state  <= FINISH;
            r_req    <= 1'b0;
            r_done   <= 1'b1;
            r_sp_we  <= 1'b1;
            r_sp_out <= w_pop_sp;
          end
        end
        PUSH: if (w_ack) begin
          r_push <= w_push_left;
          r_sp   <= w_push_sp;
          if (|w_push_left) begin
            r_addr    <= w_push_sp - 16'd2;
            r_reg_sel <= w_next_push_bit;
          end else begin
            r_state  <= FINISH;
            r_req    <= 1'b0;
            r_wr     <= 1'b0;
            r_done   <= 1'b1;
            r_sp_we  <= 1'b1;
            r_sp_out <= w_push_sp;
          end
        end
        // entered with done already set after bus work; an empty command spends one extra cycle here first
        FINISH: if (!r_done) begin
          r_done   <= 1'b1;
          r_sp_we  <= 1'b1;
          r_sp_out <= r_sp;
        end else begin
          r_done    <= 1'b0;
          r_sp_we   <= 1'b0;
          r_busy    <= 1'b0;
          r_reg_sel <= 4'd0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef STACK_SEQ_BUSLOCK_EN
  logic r_lock;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_lock <= 1'b0;
    else if (r_state == FINISH && r_done) r_lock <= 1'b0;
    else if (r_state == IDLE && start && |{pop_mask, w_in_push}) r_lock <= 1'b1;
  end
  assign bus.mem_lock = r_lock;
`else
  assign bus.mem_lock = 1'b0;
`endif
  assign bus.mem_req   = r_req;
  assign bus.mem_wr    = r_wr;
  assign bus.mem_addr  = r_addr;
  // the register file read is combinational on reg_sel, which is held for the whole request
  assign bus.mem_wdata = (r_req & r_wr) ? ((r_reg_sel == 4'd4) ? r_sp_orig : reg_rdata) : 16'd0;
  assign reg_sel   = r_reg_sel;
  assign reg_we    = r_reg_we;
  assign reg_wsel  = r_reg_wsel;
  assign reg_wdata = r_reg_wdata;
  assign sp_out    = r_sp_out;
  assign sp_we     = r_sp_we;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule
